// File: rtl/mmp_iddmm_finalsub.sv
// IDDMM final conditional subtraction: streams A and M word-serially, writes {an,A}-M
// when it is non-negative, otherwise rewrites A unchanged, then pulses comp_end.
module mmp_iddmm_finalsub #(
  parameter int N      = 32,
  parameter int K      = 128,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              comp_req,
  output logic              comp_end,
  input  logic              ref_an,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ena,
  input  logic [K-1:0]      a_rd_data,
  input  logic [K-1:0]      m_rd_data,
  output logic [ADDR_W-1:0] res_wr_addr,
  output logic [K-1:0]      res_wr_data,
  output logic              res_wr_ena,
  output logic              res_sel_sub,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, SUB, SUB_DRAIN, DEC, COPY, COPY_DRAIN, DONE} state_t;

  state_t              state, next_state;
  logic [ADDR_W-1:0]   cnt;
  logic                comp_req_d;
  logic                start;
  logic                cnt_last, drain_last;
  logic                s1_vld, s1_copy, s2_vld, s2_copy;
  logic [ADDR_W-1:0]   s1_addr, s2_addr;
  logic [K-1:0]        a_q, m_q;
  logic                borrow;
  logic [K:0]          diff;
  logic                sub_ok_now;

  assign start      = (state == IDLE) && comp_req && !comp_req_d;
  assign cnt_last   = (cnt == ADDR_W'(N - 1));
  assign drain_last = (cnt == ADDR_W'(1));
  assign diff       = {1'b0, a_q} - {1'b0, m_q} - {{K{1'b0}}, borrow};
  // The last SUB word is written in the final drain cycle, so its borrow-out is
  // used combinationally there; this lets the sub path skip DEC and finish at c0+N+3.
  assign sub_ok_now = ref_an || !diff[K];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:       if (start) next_state = SUB;
      SUB:        if (cnt_last) next_state = SUB_DRAIN;
      SUB_DRAIN:  if (drain_last) next_state = sub_ok_now ? DONE : DEC;
      DEC:        next_state = COPY;
      COPY:       if (cnt_last) next_state = COPY_DRAIN;
      COPY_DRAIN: if (drain_last) next_state = DONE;
      DONE:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    rd_ena   = (state == SUB) || (state == COPY);
    rd_addr  = rd_ena ? cnt : '0;
    busy     = (state != IDLE);
    comp_end = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || state != next_state) cnt <= '0;
    else if (state != IDLE)            cnt <= cnt + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      comp_req_d  <= 1'b0;
      s1_vld      <= 1'b0;
      s1_copy     <= 1'b0;
      s1_addr     <= '0;
      s2_vld      <= 1'b0;
      s2_copy     <= 1'b0;
      s2_addr     <= '0;
      a_q         <= '0;
      m_q         <= '0;
      borrow      <= 1'b0;
      res_sel_sub <= 1'b0;
    end else begin
      comp_req_d <= comp_req;
      s1_vld     <= rd_ena;
      s1_copy    <= (state == COPY);
      s1_addr    <= rd_addr;
      s2_vld     <= s1_vld;
      s2_copy    <= s1_copy;
      s2_addr    <= s1_addr;
      if (s1_vld) begin
        a_q <= a_rd_data;
        m_q <= m_rd_data;
      end
      if (start)                  borrow <= 1'b0;
      else if (s2_vld && !s2_copy) borrow <= diff[K];
      if (start)
        res_sel_sub <= 1'b0;
      else if (state == SUB_DRAIN && drain_last)
        res_sel_sub <= sub_ok_now;
    end
  end

  assign res_wr_ena  = s2_vld;
  assign res_wr_addr = s2_addr;
  assign res_wr_data = s2_copy ? a_q : diff[K-1:0];

endmodule

// File: tb/tb_mmp_iddmm_finalsub.sv
// Scoreboard bench for mmp_iddmm_finalsub with N=4, K=8 and behavioural A/M/result RAMs.
module tb_mmp_iddmm_finalsub;
  localparam int N      = 4;
  localparam int K      = 8;
  localparam int ADDR_W = 2;
  localparam int W      = N * K;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              comp_req = 1'b0;
  logic              comp_end;
  logic              ref_an = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ena;
  logic [K-1:0]      a_rd_data = '0;
  logic [K-1:0]      m_rd_data = '0;
  logic [ADDR_W-1:0] res_wr_addr;
  logic [K-1:0]      res_wr_data;
  logic              res_wr_ena;
  logic              res_sel_sub;
  logic              busy;

  logic [K-1:0] a_mem   [N];
  logic [K-1:0] m_mem   [N];
  logic [K-1:0] res_mem [N];
  logic         clr_res = 1'b0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [K-1:0]      data;
  } wr_t;
  wr_t exp_q[$];

  int total = 0;
  int bad   = 0;

  mmp_iddmm_finalsub #(.N(N), .K(K), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .comp_req(comp_req), .comp_end(comp_end),
    .ref_an(ref_an), .rd_addr(rd_addr), .rd_ena(rd_ena),
    .a_rd_data(a_rd_data), .m_rd_data(m_rd_data),
    .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data), .res_wr_ena(res_wr_ena),
    .res_sel_sub(res_sel_sub), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_ena) begin
      a_rd_data <= a_mem[rd_addr];
      m_rd_data <= m_mem[rd_addr];
    end
  end

  always @(posedge clk) begin
    if (clr_res) begin
      for (int i = 0; i < N; i++) res_mem[i] <= 8'hAA;
    end else if (res_wr_ena) begin
      res_mem[res_wr_addr] <= res_wr_data;
    end
  end

  task automatic load_mems(input logic [W-1:0] a, input logic [W-1:0] m);
    for (int k = 0; k < N; k++) begin
      a_mem[k] = a[k*K +: K];
      m_mem[k] = m[k*K +: K];
    end
    @(negedge clk); clr_res = 1'b1;
    @(negedge clk); clr_res = 1'b0;
  endtask

  // One full request: expectations come from a whole-operand subtraction.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] m,
                        input logic an, input int hold);
    logic [W:0]   d;
    logic         ok;
    logic [W-1:0] fin, got_fin;
    int           exp_lat, lat, ends, cyc;
    wr_t          w;
    d   = {1'b0, a} - {1'b0, m};
    ok  = an | ~d[W];
    fin = ok ? d[W-1:0] : a;
    exp_lat = ok ? N + 3 : 2 * N + 6;
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back('{addr: ADDR_W'(k), data: d[k*K +: K]});
    if (!ok)
      for (int k = 0; k < N; k++) exp_q.push_back('{addr: ADDR_W'(k), data: a[k*K +: K]});
    load_mems(a, m);
    @(negedge clk);
    ref_an = an;
    comp_req = 1'b1;
    lat = 0; ends = 0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_c1 got=%b exp=1", name, busy); end
      end
      if (res_wr_ena === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL %s extra_write cyc=%0d addr=%0d data=%h", name, cyc, res_wr_addr, res_wr_data);
        end else begin
          w = exp_q.pop_front();
          if (res_wr_addr !== w.addr || res_wr_data !== w.data) begin
            bad++;
            $display("FAIL %s write got=%0d:%h exp=%0d:%h", name, res_wr_addr, res_wr_data, w.addr, w.data);
          end
        end
      end
      if (comp_end === 1'b1) begin
        ends++;
        if (lat == 0) lat = cyc;
      end
      if (lat != 0 && cyc == lat + hold) comp_req = 1'b0;
      if (lat != 0 && cyc >= lat + hold + 3) break;
    end
    comp_req = 1'b0;
    total++;
    if (lat != exp_lat) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat); end
    total++;
    if (ends != 1) begin bad++; $display("FAIL %s comp_end_pulses got=%0d exp=1", name, ends); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL %s missing_writes got=%0d exp=0", name, exp_q.size()); end
    total++;
    if (res_sel_sub !== ok) begin bad++; $display("FAIL %s res_sel_sub got=%b exp=%b", name, res_sel_sub, ok); end
    for (int k = 0; k < N; k++) got_fin[k*K +: K] = res_mem[k];
    total++;
    if (got_fin !== fin) begin bad++; $display("FAIL %s ram got=%h exp=%h", name, got_fin, fin); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({busy, comp_end, rd_ena, res_wr_ena, res_sel_sub, rd_addr, res_wr_addr, res_wr_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b%b%b%b%b %h %h %h exp=all0", busy, comp_end, rd_ena,
               res_wr_ena, res_sel_sub, rd_addr, res_wr_addr, res_wr_data);
    end
  endtask

  task automatic test_sub_path();
    run_op("sub_path", 32'h05000010, 32'h01000020, 1'b0, 1);
  endtask

  task automatic test_copy_path();
    run_op("copy_path", 32'h00000010, 32'h00000020, 1'b0, 1);
  endtask

  task automatic test_an_set();
    run_op("an_set", 32'h00000001, 32'h00000002, 1'b1, 1);
  endtask

  task automatic test_equal();
    logic [W-1:0] v;
    for (int i = 0; i < 2; i++) begin
      v = W'($urandom);
      run_op("a_eq_m", v, v, 1'b0, 1);
    end
  endtask

  task automatic test_reset_mid_op();
    int viol;
    load_mems(32'h11223344, 32'h01010101);
    @(negedge clk); ref_an = 1'b0; comp_req = 1'b1;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0; comp_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    total++;
    if (busy !== 1'b0 || res_wr_ena !== 1'b0 || comp_end !== 1'b0) begin
      bad++; $display("FAIL abort_state busy=%b wr=%b end=%b exp=0", busy, res_wr_ena, comp_end);
    end
    viol = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_wr_ena !== 1'b0 || comp_end !== 1'b0 || busy !== 1'b0) viol++;
    end
    total++;
    if (viol != 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", viol); end
    run_op("after_abort", 32'h11223344, 32'h01010101, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    run_op("held_req", 32'h00000001, 32'h00000002, 1'b1, 4);
    run_op("second_run", 32'h12345678, 32'h01020304, 1'b0, 1);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin a_mem[k] = '0; m_mem[k] = '0; end
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_sub_path();
    test_copy_path();
    test_an_set();
    test_equal();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
